// File: rtl/reg_file_scoreboard.sv
// 16-entry register file with a per-register pending-write scoreboard for decode.
// Reads are combinational with same-cycle writeback bypass; errors are sticky until reset.
module reg_file_scoreboard #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        srcReg1,
    input  logic [3:0]        srcReg2,
    input  logic [3:0]        nextDestReg,
    input  logic              reserve,
    input  logic              wbEn,
    input  logic [3:0]        wbReg,
    input  logic [DATA_W-1:0] wbVal,
    output logic [DATA_W-1:0] srcRegVal1,
    output logic [DATA_W-1:0] srcRegVal2,
    output logic              inuse1,
    output logic              inuse2,
    output logic              scbErr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];
    logic [CNT_W-1:0]  cnt_q  [16];
    logic [CNT_W-1:0]  cnt_d  [16];
    logic              scb_err_q, scb_err_d;
    logic              same_idx;

    // A reserve and a writeback on the same register cancel in the counter.
    assign same_idx = reserve && wbEn && (nextDestReg == wbReg);

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
            cnt_d[i]  = cnt_q[i];
        end
        scb_err_d = scb_err_q;

        if (wbEn) begin
            regs_d[wbReg] = wbVal;
            if (!same_idx) begin
                if (cnt_q[wbReg] == '0) scb_err_d = 1'b1;
                else                    cnt_d[wbReg] = cnt_q[wbReg] - CNT_ONE;
            end
        end

        if (reserve && !same_idx) begin
            if (cnt_q[nextDestReg] == CNT_MAX) scb_err_d = 1'b1;
            else                               cnt_d[nextDestReg] = cnt_q[nextDestReg] + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            scb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            scb_err_q <= scb_err_d;
        end
    end

    // Read ports: the in-flight writeback counts as already retired, so
    // in-use drops one cycle early and never goes negative.
    logic [3:0]        src   [2];
    logic [DATA_W-1:0] rd_val[2];
    logic              rd_use[2];
    logic              wb_hit[2];

    assign src[0] = srcReg1;
    assign src[1] = srcReg2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wb_hit[p] = wbEn && (wbReg == src[p]);
            rd_val[p] = wb_hit[p] ? wbVal : regs_q[src[p]];
            rd_use[p] = wb_hit[p] ? (cnt_q[src[p]] > CNT_ONE) : (cnt_q[src[p]] != '0);
        end
    end

    assign srcRegVal1 = rd_val[0];
    assign srcRegVal2 = rd_val[1];
    assign inuse1     = rd_use[0];
    assign inuse2     = rd_use[1];
    assign scbErr     = scb_err_q;

endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

- Register file and in-use scoreboard serving the decode stage of the 3-stage pipeline (fetch → decode → execute).
- Decode drives register indices. This block returns operand values and in-use flags combinationally, so decode can register them at the next clock edge.
- Decode reserves its destination register at issue. Execute writes results back, which releases the reservation.
- A per-register pending counter tracks more than one in-flight write to the same register.

## Interface
Parameters:
- DATA_W, 16, register/data width
- CNT_W, 2, pending-write counter width per register (max in-flight writes per register = 2^CNT_W − 1)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- srcReg1  in  4  read index, port 1
- srcReg2  in  4  read index, port 2
- nextDestReg  in  4  destination index being issued by decode
- reserve  in  1  decode issues a register-writing instruction this cycle (not asserted for STORE or bubbles)
- wbEn  in  1  execute writeback valid
- wbReg  in  4  writeback index
- wbVal  in  DATA_W  writeback data
- srcRegVal1  out  DATA_W  operand value, port 1
- srcRegVal2  out  DATA_W  operand value, port 2
- inuse1  out  1  register srcReg1 has a pending write
- inuse2  out  1  register srcReg2 has a pending write
- scbErr  out  1  sticky scoreboard error (overflow/underflow)

## Operation
- **State:**
  - regs[0..15], DATA_W each; register 0 is an ordinary register.
  - cnt[0..15], CNT_W each.
  - scbErr flop.
- **Reset (rst low, asynchronous):**
  - All regs = 0, all cnt = 0, scbErr = 0.
  - Outputs therefore read srcRegVal = 0 and inuse = 0 while in reset.
- **Write (posedge, wbEn=1):**
  - regs[wbReg] ← wbVal.
  - cnt[wbReg] decrements.
- **Reserve (posedge, reserve=1):** cnt[nextDestReg] increments.
- **Simultaneous reserve and writeback:**
  - Same index: cnt unchanged, data written.
  - Different indices: both updates apply independently.
- **Overflow:**
  - Condition: reserve while cnt[nextDestReg] is at its maximum (all ones) and that register is not simultaneously written back.
  - cnt saturates (unchanged) and scbErr ← 1.
- **Underflow:**
  - Condition: wbEn while cnt[wbReg]==0 and that register is not simultaneously reserved.
  - Data is still written, cnt stays 0, scbErr ← 1.
- scbErr clears only on reset.
- **Read (combinational, per port p with index s = srcRegp):**
  - Bypass: if wbEn and wbReg==s, srcRegValp = wbVal; otherwise srcRegValp = regs[s].
  - In-use: inusep = (cnt[s] − (wbEn && wbReg==s ? 1 : 0)) != 0, clamped at 0 on underflow.
  - The current cycle's reserve is excluded from inusep. An instruction reading its own destination (e.g. ADD r3,r3,r1) therefore does not stall on itself.
- Both read ports are independent and may carry the same index; both then return identical results.

## Timing
- Read latency: 0 cycles, combinational from srcReg*, wbEn, wbReg, wbVal and state. No path from reserve or nextDestReg to any output.
- A writeback is visible:
  - on the read ports in the same cycle (bypass);
  - in regs/cnt from the next cycle.
- A reservation is visible on inuse from the cycle after the posedge that samples reserve.
- Reset assertion clears state immediately, without waiting for clk. This includes mid-operation with pending counts nonzero. After release, the first posedge behaves normally.

## Test plan
- **Reset:**
  - Stimulus: preload r5=40 via wbEn, leave cnt[2]=1, then pulse rst low between clock edges.
  - Required: srcRegVal1=0 and inuse1=0 for all indices immediately; scbErr=0.
- **Reserve/writeback round trip:**
  - Stimulus: reserve r3 at cycle 0; srcReg1=3.
  - Required: inuse1=1 from cycle 1.
  - Stimulus: wbEn, wbReg=3, wbVal=50 at cycle 2.
  - Required: in the same cycle srcRegVal1=50 (bypass) and inuse1=0; from cycle 3 regs[3]=50 and inuse1=0.
- **Multiple in-flight writes:**
  - Stimulus: reserve r7 twice on consecutive cycles, then one writeback of 80.
  - Required: inuse2 stays 1 with srcRegVal2=80.
  - Stimulus: second writeback of 90.
  - Required: inuse2=0, srcRegVal2=90.
- **Self-read and simultaneous events:**
  - Stimulus: srcReg1=4, nextDestReg=4, reserve=1 with cnt[4]=0.
  - Required: inuse1=0 that cycle, 1 the next.
  - Stimulus: reserve and wbEn on r4 in the same cycle.
  - Required: cnt[4] is unchanged.
- **Overflow/underflow:**
  - Stimulus: four reserves of r9 with CNT_W=2.
  - Required: scbErr=1 after the 4th edge, cnt[9]=3.
  - Stimulus: after reset, a writeback to r1 with cnt[1]=0.
  - Required: regs[1] updated, scbErr=1.
- **Dual-port same index:**
  - Stimulus: srcReg1=srcReg2=6 with regs[6]=0xBEEF.
  - Required: both ports return 0xBEEF with identical inuse.
